// File: rtl/tile_skew_feeder.sv
// Skews BRAM port-B rows into a diagonal per-lane stream for the systolic array and tracks tile completion.
// Optional macro SKEW_OUT_REG_EN adds one output register stage on sa_data, sa_valid and tile_done.
module tile_skew_feeder #(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned NUM_BITS      = 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned ROW_CNT_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      bram_en,
  input  logic                                      fetch_done,
  input  logic [DATA_WIDTH-1:0]                     bram_dout,
  output logic [DATA_WIDTH-1:0]                     sa_data,
  output logic [DATA_WIDTH/NUM_BITS-1:0]            sa_valid,
  output logic                                      tile_done,
  output logic                                      busy,
  output logic [ROW_CNT_WIDTH-1:0]                  rows_in_tile
);

  localparam int unsigned LANES = DATA_WIDTH / NUM_BITS;
  localparam int unsigned CNT_W = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   drain_cnt, drain_cnt_n;
  logic               pend, pend_n;

  logic [READ_LATENCY-1:0] en_sr, last_sr;
  logic                    in_valid, in_last;
  logic [LANES-1:0]        last_pipe;
  logic [LANES-1:0]        fin_valid, lane_pend;
  logic [DATA_WIDTH-1:0]   fin_data;
  logic                    after_last;
  logic                    out_pend;

  // Align enable/last with the BRAM read data; fetch_done only counts alongside a read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sr   <= '0;
      last_sr <= '0;
    end else begin
      en_sr[0]   <= bram_en;
      last_sr[0] <= bram_en & fetch_done;
      for (int i = 1; i < READ_LATENCY; i++) begin
        en_sr[i]   <= en_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign in_valid = en_sr[READ_LATENCY-1];
  assign in_last  = last_sr[READ_LATENCY-1];

  // Lane k: k+1 stage shift register, data zeroed at entry so invalid slots carry 0
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [k:0]          v;
    logic [NUM_BITS-1:0] d [k+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= '0;
        for (int j = 0; j <= k; j++) d[j] <= '0;
      end else begin
        v[0] <= in_valid;
        d[0] <= in_valid ? bram_dout[k*NUM_BITS +: NUM_BITS] : '0;
        for (int j = 1; j <= k; j++) begin
          v[j] <= v[j-1];
          d[j] <= d[j-1];
        end
      end
    end

    assign fin_valid[k]                     = v[k];
    assign fin_data[k*NUM_BITS +: NUM_BITS] = d[k];
    if (k == 0) begin : g_first
      assign lane_pend[k] = 1'b0;
    end else begin : g_rest
      assign lane_pend[k] = |v[k-1:0];
    end
  end

  // Last-row marker travels alongside the deepest lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_pipe <= '0;
    else     last_pipe <= {last_pipe[LANES-2:0], in_valid & in_last};
  end

`ifdef SKEW_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_data   <= '0;
      sa_valid  <= '0;
      tile_done <= 1'b0;
    end else begin
      sa_data   <= fin_data;
      sa_valid  <= fin_valid;
      tile_done <= last_pipe[LANES-1];
    end
  end
  assign out_pend = |fin_valid;
`else
  assign sa_data   = fin_data;
  assign sa_valid  = fin_valid;
  assign tile_done = last_pipe[LANES-1];
  assign out_pend  = 1'b0;
`endif

  // Row counter restarts on the first row after a tile's last row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_in_tile <= '0;
      after_last   <= 1'b0;
    end else if (in_valid) begin
      if (after_last)              rows_in_tile <= ROW_CNT_WIDTH'(1);
      else if (rows_in_tile != '1) rows_in_tile <= rows_in_tile + ROW_CNT_WIDTH'(1);
      after_last <= in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      pend      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      pend      <= pend_n;
      busy      <= (state_n != S_IDLE) | in_valid | (|lane_pend) | out_pend;
    end
  end

  // A later tile's last row restarts the drain window so the FSM idles only after the final tile
  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    pend_n      = pend;
    case (state)
      S_IDLE: begin
        if (in_valid && in_last) begin
          state_n     = S_DRAIN;
          drain_cnt_n = CNT_W'(LANES-1);
          pend_n      = 1'b0;
        end else if (in_valid) begin
          state_n = S_FEED;
        end
      end
      S_FEED: begin
        if (in_valid && in_last) begin
          state_n     = S_DRAIN;
          drain_cnt_n = CNT_W'(LANES-1);
          pend_n      = 1'b0;
        end
      end
      S_DRAIN: begin
        if (in_valid && in_last) begin
          drain_cnt_n = CNT_W'(LANES-1);
          pend_n      = 1'b0;
        end else if (drain_cnt == '0) begin
          state_n = (pend || in_valid) ? S_FEED : S_IDLE;
          pend_n  = 1'b0;
        end else begin
          drain_cnt_n = drain_cnt - CNT_W'(1);
          if (in_valid) pend_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
